// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like request channels onto one
// AXI3 master port, single-beat transfers, one transaction in flight.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t     state_reg;
  logic       src_data_reg;
  logic [3:0] wstrb_next;

  // Response IDs, status and rlast carry no information for single-beat,
  // single-outstanding traffic.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  // Data has priority; grants are combinational so a request can be taken in
  // the same cycle it is presented, and are suppressed while in reset.
  assign data_addr_ok = rst && (state_reg == IDLE) && data_req;
  assign inst_addr_ok = rst && (state_reg == IDLE) && inst_req && !data_req;

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = ID_DATA;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;

  // Byte lane enables from size and the low address bits of the request.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign wstrb_next[gi] = (data_size == 2'd2)
                            || ((data_size == 2'd1) && (data_addr[1] == LANE[1]))
                            || ((data_size == 2'd0) && (data_addr[1:0] == LANE));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      src_data_reg <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
      arid         <= 4'd0;
      araddr       <= 32'd0;
      arsize       <= 3'd0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awaddr       <= 32'd0;
      awsize       <= 3'd0;
      awvalid      <= 1'b0;
      wdata        <= 32'd0;
      wstrb        <= 4'd0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (data_req) begin
            src_data_reg <= 1'b1;
            if (data_wr) begin
              awaddr    <= data_addr;
              awsize    <= {1'b0, data_size};
              awvalid   <= 1'b1;
              wdata     <= data_wdata;
              wstrb     <= wstrb_next;
              wvalid    <= 1'b1;
              state_reg <= WR_REQ;
            end else begin
              arid      <= ID_DATA;
              araddr    <= data_addr;
              arsize    <= {1'b0, data_size};
              arvalid   <= 1'b1;
              state_reg <= RD_ADDR;
            end
          end else if (inst_req) begin
            src_data_reg <= 1'b0;
            arid         <= ID_INST;
            araddr       <= inst_addr;
            arsize       <= 3'd2;
            arvalid      <= 1'b1;
            state_reg    <= RD_ADDR;
          end
        end

        RD_ADDR: begin
          if (arready) begin
            arvalid   <= 1'b0;
            rready    <= 1'b1;
            state_reg <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (src_data_reg) begin
              data_rdata   <= rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= rdata;
              inst_data_ok <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end

        WR_REQ: begin
          // AW and W retire independently; move on once neither is pending.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready    <= 1'b1;
            state_reg <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            bready       <= 1'b0;
            data_data_ok <= 1'b1;
            state_reg    <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: an in-bench AXI slave with per-transaction
// wait states and a scoreboard of expected data_ok events.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  cpu_axi_bridge #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          src;   // 1 = data channel
    bit          rd;
    logic [31:0] val;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] model_inst, model_data;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    sb_t e;
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (e.rd) begin
      if (e.src) model_data = e.val;
      else       model_inst = e.val;
    end
    chk({tag, "_ok_pair"}, {inst_data_ok, data_data_ok}, {!e.src, e.src});
    chk({tag, "_inst_rdata"}, inst_rdata, model_inst);
    chk({tag, "_data_rdata"}, data_rdata, model_data);
  endtask

  task automatic do_read(input bit is_data, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] val, input int ar_dly, input int r_dly);
    int          c0;
    sb_t         e;
    logic [2:0]  xsize;
    logic [3:0]  xid;
    xsize = is_data ? {1'b0, size} : 3'd2;
    xid   = is_data ? 4'd1 : 4'd0;
    if (is_data) begin
      data_req = 1'b1; data_wr = 1'b0; data_size = size; data_addr = addr;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    #1;
    chk("rd_grant", {data_addr_ok, inst_addr_ok}, {is_data, !is_data});
    e.src = is_data; e.rd = 1'b1; e.val = val;
    sb.push_back(e);
    c0 = cyc;
    @(negedge clk);
    if (is_data) data_req = 1'b0;
    else         inst_req = 1'b0;
    #1;
    chk("rd_no_ok_pulse", {inst_data_ok, data_data_ok}, 2'b00);
    for (int i = 0; i <= ar_dly; i++) begin
      if (i == 0) begin
        chk("arid", arid, xid);
        chk("arsize", arsize, xsize);
        chk("ar_fixed", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
      end
      chk("arvalid", arvalid, 1'b1);
      chk("araddr", araddr, addr);
      chk("rd_addr_ok_busy", {inst_addr_ok, data_addr_ok}, 2'b00);
      if (i == ar_dly) arready = 1'b1;
      @(negedge clk);
    end
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 1'b0);
    for (int i = 0; i <= r_dly; i++) begin
      chk("rready", rready, 1'b1);
      chk("rd_wait_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
      chk("rd_wait_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      if (i == r_dly) begin rvalid = 1'b1; rdata = val; end
      @(negedge clk);
    end
    rvalid = 1'b0;
    rdata  = $urandom;
    chk("rd_latency", 32'(cyc - c0), 32'(3 + ar_dly + r_dly));
    chk("rready_drop", rready, 1'b0);
    pop_check("rd");
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                          input logic [3:0] xstrb, input int aw_dly, input int w_dly, input int b_dly);
    int  c0, c;
    bit  aw_done, w_done;
    sb_t e;
    data_req = 1'b1; data_wr = 1'b1; data_size = size; data_addr = addr; data_wdata = wd;
    #1;
    chk("wr_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
    e.src = 1'b1; e.rd = 1'b0; e.val = 32'd0;
    sb.push_back(e);
    c0 = cyc;
    @(negedge clk);
    data_req = 1'b0;
    data_wdata = $urandom;
    #1;
    chk("wr_no_ok_pulse", {inst_data_ok, data_data_ok}, 2'b00);
    chk("awaddr", awaddr, addr);
    chk("awsize", awsize, {1'b0, size});
    chk("wdata", wdata, wd);
    chk("wstrb", wstrb, xstrb);
    chk("wr_ids", {awid, wid}, 8'h11);
    chk("aw_fixed", {awlen, awburst, awlock, awcache, awprot, wlast}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
    aw_done = 1'b0; w_done = 1'b0; c = 0;
    while (!(aw_done && w_done)) begin
      chk("awvalid", awvalid, !aw_done);
      chk("wvalid", wvalid, !w_done);
      chk("bready_early", bready, 1'b0);
      chk("wr_addr_ok_busy", {inst_addr_ok, data_addr_ok}, 2'b00);
      awready = !aw_done && (c >= aw_dly);
      wready  = !w_done && (c >= w_dly);
      @(negedge clk);
      if (awready) aw_done = 1'b1;
      if (wready)  w_done  = 1'b1;
      c++;
    end
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i <= b_dly; i++) begin
      chk("bready", bready, 1'b1);
      chk("wr_valids_low", {awvalid, wvalid}, 2'b00);
      chk("wr_wait_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
      if (i == b_dly) bvalid = 1'b1;
      @(negedge clk);
    end
    bvalid = 1'b0;
    chk("wr_latency", 32'(cyc - c0), 32'(3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly));
    chk("bready_drop", bready, 1'b0);
    pop_check("wr");
  endtask

  initial begin
    rst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0000; data_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;
    model_inst = 32'd0; model_data = 32'd0;

    // Reset state, with both requests asserted during reset.
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'd0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    chk("rst_addrs", araddr | awaddr | wdata, 32'd0);
    inst_req = 1'b0; data_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Instruction fetch, zero-wait slave.
    do_read(1'b0, 32'hBFC0_0000, 2'd2, 32'h3C1D_0000, 0, 0);
    // Byte store to the top lane.
    do_write(32'h8000_0003, 2'd0, 32'hAB00_0000, 4'b1000, 0, 0, 0);
    // Word load.
    do_read(1'b1, 32'h8000_1000, 2'd2, 32'h1234_5678, 0, 0);

    // Simultaneous requests: data first, inst granted in the data_ok cycle.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    do_read(1'b1, 32'h8000_2002, 2'd1, 32'hCAFE_F00D, 0, 0);
    do_read(1'b0, 32'hBFC0_0004, 2'd2, 32'h27BD_FFF8, 0, 0);

    // W two cycles ahead of AW, B five cycles late.
    do_write(32'h8000_0010, 2'd2, 32'hDEAD_BEEF, 4'b1111, 2, 0, 5);
    // Halfword store with W late; byte store with AW/W together.
    do_write(32'h8000_0022, 2'd1, 32'h5A5A_0000, 4'b1100, 0, 1, 0);
    do_write(32'h8000_0081, 2'd0, 32'h0000_7700, 4'b0010, 0, 0, 1);

    // Slow read while a fetch is pending on the other channel.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    do_read(1'b1, 32'h8000_3000, 2'd0, 32'h0000_00A5, 3, 4);
    do_read(1'b0, 32'hBFC0_0008, 2'd2, 32'h0000_0000, 0, 0);

    // Reset while waiting in RD_DATA abandons the read.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000_0040;
    #1;
    chk("mid_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
    @(negedge clk);
    data_req = 1'b0;
    chk("mid_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("mid_rready", rready, 1'b1);
    #2 rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("mid_rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'd0);
    chk("mid_rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    chk("mid_rst_rdata", inst_rdata | data_rdata, 32'd0);
    model_inst = 32'd0; model_data = 32'd0;
    @(negedge clk);
    rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
    chk("post_rst_idle", {arvalid, rready, awvalid, wvalid, bready}, 5'd0);
    do_read(1'b0, 32'hBFC0_0000, 2'd2, 32'h1122_3344, 1, 2);
    do_read(1'b1, 32'h8000_0004, 2'd2, 32'h5566_7788, 0, 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the CPU core's two SRAM-like request channels (instruction fetch, data load/store) into a single AXI3 master port, one outstanding transaction at a time. Sits directly downstream of `mycpu_core`'s memory interfaces, between the core and the SoC interconnect. Data requests take priority over instruction requests. Each transfer is a single beat; bursts are never issued.

## Interface
Parameters:
- `ID_INST`, 4'd0, AXI ID used for instruction reads
- `ID_DATA`, 4'd1, AXI ID used for data reads and writes

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `inst_req`  in  1  fetch request; held until `inst_addr_ok`
- `inst_addr`  in  32  fetch byte address, word aligned
- `inst_addr_ok`  out  1  fetch request accepted this cycle
- `inst_data_ok`  out  1  one-cycle pulse: `inst_rdata` valid
- `inst_rdata`  out  32  fetched word
- `data_req`  in  1  load/store request; held until `data_addr_ok`
- `data_wr`  in  1  1 = store, 0 = load
- `data_size`  in  2  0 byte, 1 half, 2 word
- `data_addr`  in  32  byte address, naturally aligned for `data_size`
- `data_wdata`  in  32  store data, already lane-positioned
- `data_addr_ok`  out  1  data request accepted this cycle
- `data_data_ok`  out  1  one-cycle pulse: load data valid or store complete
- `data_rdata`  out  32  loaded word (raw; the core extracts lanes)
- AR: `arid` 4, `araddr` 32, `arlen` 8, `arsize` 3, `arburst` 2, `arlock` 2, `arcache` 4, `arprot` 3, `arvalid` 1 out; `arready` 1 in
- R: `rid` 4, `rdata` 32, `rresp` 2, `rlast` 1, `rvalid` 1 in; `rready` 1 out
- AW: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot` (widths as AR), `awvalid` out; `awready` in
- W: `wid` 4, `wdata` 32, `wstrb` 4, `wlast` 1, `wvalid` 1 out; `wready` 1 in
- B: `bid` 4, `bresp` 2, `bvalid` 1 in; `bready` 1 out

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: if `data_req`, grant data (`data_addr_ok`=1); else if `inst_req`, grant inst (`inst_addr_ok`=1). Both `addr_ok` are 0 outside IDLE. At grant, latch source, addr, size, wr, wdata; go to RD_ADDR (read) or WR_REQ (store).
- RD_ADDR: `arvalid`=1; on `arready` go to RD_DATA.
- RD_DATA: `rready`=1; on `rvalid`, capture `rdata` into the granted source's rdata register, go to IDLE.
- WR_REQ: `awvalid` and `wvalid` both asserted on entry; each drops independently after its own handshake (AW and W may complete in either order or the same cycle). When both are done, go to WR_RESP.
- WR_RESP: `bready`=1; on `bvalid` go to IDLE.
- `data_ok` of the granted source is registered: it pulses the cycle after the R or B handshake. `*_rdata` holds its value until that source's next read completes.
- Fixed fields: `arlen`/`awlen`=0, `*burst`=2'b01, `*lock`/`*cache`/`*prot`=0, `wlast`=1. `arid` is `ID_DATA` or `ID_INST` by source; `awid` and `wid` are `ID_DATA`.
- Size: `arsize`/`awsize` = {1'b0, size}; instruction size is always 2.
- `wstrb`: size0 -> 4'b0001<<addr[1:0]; size1 -> 4'b0011<<addr[1:0]; size2 -> 4'b1111.
- `rresp`/`bresp`/`rid`/`bid` are ignored; errors are not reported.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; all AXI valid/ready outputs 0; both `data_ok` 0; both `rdata` 0; address/data outputs 0. `addr_ok` forced 0 while `rst`=0.
- Reset mid-transaction abandons it: no `data_ok` is generated, and the bridge returns to IDLE.
- Read: `addr_ok` at cycle T. `arvalid` from T+1. With zero-wait AXI (`arready` at T+1, `rvalid` at T+2), `data_ok` is at T+3.
- Write: `addr_ok` at T. `awvalid`/`wvalid` from T+1. With zero-wait AXI (`bvalid` at T+2), `data_ok` is at T+3.
- Next grant is possible in the cycle after the R/B handshake, which is the same cycle as the `data_ok` pulse.
- Simultaneous `inst_req` and `data_req` in IDLE: data wins. The inst request stays pending and is granted at the next IDLE.
- AXI outputs change only on `clk`, except during asynchronous reset.

## Test plan
- Single inst read, addr 0xBFC00000, zero-wait slave returns 0x3C1D0000 -> `arid`=0 and `arsize`=2; `inst_addr_ok` at T; `inst_data_ok` at T+3 with `inst_rdata`=0x3C1D0000.
- Byte store: size 0, addr 0x80000003, wdata 0xAB000000 -> `wstrb`=4'b1000, `awsize`=0, `awid`=`wid`=1; `data_data_ok` one cycle after `bvalid`.
- `inst_req` and `data_req` (load) asserted together -> data granted first. Inst is granted in the cycle of `data_data_ok`, and each `data_ok` pulses exactly once.
- Write with W handshake 2 cycles before AW, then B delayed 5 cycles -> `wvalid` drops after W handshake; `bready` rises only after both handshakes; single `data_data_ok`.
- Read with `arready` delayed 3 cycles and `rvalid` delayed 4 -> `arvalid` held stable with constant `araddr`; no `addr_ok` on either channel until return to IDLE.
- `rst` asserted while in RD_DATA -> all valids and readies drop immediately; no `data_ok`. After release, a new request completes normally.
